// File: rtl/modu_exp_ctrl.sv
// Modular exponentiation sequencer: result = base^exponent mod modulus by
// left-to-right square-and-multiply, driving an external modular multiplier.
module modu_exp_ctrl #(
  parameter int unsigned NLEN = 32,
  parameter int unsigned ELEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            strobe,
  input  logic [NLEN-1:0] base,
  input  logic [ELEN-1:0] exponent,
  input  logic [NLEN-1:0] modulus,
  output logic [NLEN-1:0] result,
  output logic            ready,
  output logic            busy,
  output logic            err,
  output logic            mul_strobe,
  output logic [NLEN-1:0] mul_x,
  output logic [NLEN-1:0] mul_y,
  output logic [NLEN-1:0] mul_m,
  input  logic [NLEN-1:0] mul_p,
  input  logic            mul_ready
);

  localparam int unsigned IW = (ELEN > 1) ? $clog2(ELEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REDUCE,
    S_REDUCE_W,
    S_SQR,
    S_SQR_W,
    S_MUL,
    S_MUL_W,
    S_NEXT,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [NLEN-1:0] b_q;
  logic [ELEN-1:0] e_q;
  logic [NLEN-1:0] r_q;
  logic [IW-1:0]   i_q;
  logic            first_q;
  logic [NLEN-1:0] result_q;
  logic            ready_q;
  logic            busy_q;
  logic            err_q;
  logic            mul_strobe_q;
  logic [NLEN-1:0] mul_x_q;
  logic [NLEN-1:0] mul_y_q;
  logic [NLEN-1:0] mul_m_q;
  logic            mul_done;

  // A *_W state never accepts mul_ready in its first cycle: the multiplier may
  // still be showing the level-ready of the previous operation there.
  assign mul_done = mul_ready && !first_q;

  // Multiplier operands are loaded on the transition into an issue state, so
  // mul_strobe is high while the FSM sits in REDUCE/SQR/MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      b_q          <= '0;
      e_q          <= '0;
      r_q          <= '0;
      i_q          <= '0;
      first_q      <= 1'b0;
      result_q     <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      mul_strobe_q <= 1'b0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      mul_m_q      <= '0;
    end else begin
      mul_strobe_q <= 1'b0;
      ready_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (strobe) begin
            b_q     <= base;
            e_q     <= exponent;
            mul_m_q <= modulus;
            i_q     <= IW'(ELEN - 1);
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            if (modulus == '0) begin
              r_q     <= '0;
              state_q <= S_DONE;
            end else begin
              r_q          <= (modulus == NLEN'(1)) ? '0 : NLEN'(1);
              mul_x_q      <= base;
              mul_y_q      <= NLEN'(1);
              mul_strobe_q <= 1'b1;
              state_q      <= S_REDUCE;
            end
          end
        end
        S_REDUCE: begin
          first_q <= 1'b1;
          state_q <= S_REDUCE_W;
        end
        S_REDUCE_W: begin
          first_q <= 1'b0;
          if (mul_done) begin
            b_q          <= mul_p;
            mul_x_q      <= r_q;
            mul_y_q      <= r_q;
            mul_strobe_q <= 1'b1;
            state_q      <= S_SQR;
          end
        end
        S_SQR: begin
          first_q <= 1'b1;
          state_q <= S_SQR_W;
        end
        S_SQR_W: begin
          first_q <= 1'b0;
          if (mul_done) begin
            r_q <= mul_p;
            if (e_q[i_q]) begin
              mul_x_q      <= mul_p;
              mul_y_q      <= b_q;
              mul_strobe_q <= 1'b1;
              state_q      <= S_MUL;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_MUL: begin
          first_q <= 1'b1;
          state_q <= S_MUL_W;
        end
        S_MUL_W: begin
          first_q <= 1'b0;
          if (mul_done) begin
            r_q     <= mul_p;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (i_q == '0) begin
            state_q <= S_DONE;
          end else begin
            i_q          <= i_q - IW'(1);
            mul_x_q      <= r_q;
            mul_y_q      <= r_q;
            mul_strobe_q <= 1'b1;
            state_q      <= S_SQR;
          end
        end
        S_DONE: begin
          result_q <= r_q;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          err_q    <= (mul_m_q == '0);
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result     = result_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign mul_strobe = mul_strobe_q;
  assign mul_x      = mul_x_q;
  assign mul_y      = mul_y_q;
  assign mul_m      = mul_m_q;

endmodule

// File: tb/tb_modu_exp_ctrl.sv
// Scoreboard bench for modu_exp_ctrl with a level-ready behavioural multiplier
// of fixed latency L; expected results and latencies are hand-computed.
module tb_modu_exp_ctrl;

  localparam int unsigned NLEN = 32;
  localparam int unsigned ELEN = 32;
  localparam int unsigned L    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            strobe;
  logic [NLEN-1:0] base;
  logic [ELEN-1:0] exponent;
  logic [NLEN-1:0] modulus;
  logic [NLEN-1:0] result;
  logic            ready;
  logic            busy;
  logic            err;
  logic            mul_strobe;
  logic [NLEN-1:0] mul_x;
  logic [NLEN-1:0] mul_y;
  logic [NLEN-1:0] mul_m;
  logic [NLEN-1:0] mul_p = '0;
  logic            mul_ready = 1'b0;

  modu_exp_ctrl #(.NLEN(NLEN), .ELEN(ELEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe     (strobe),
    .base       (base),
    .exponent   (exponent),
    .modulus    (modulus),
    .result     (result),
    .ready      (ready),
    .busy       (busy),
    .err        (err),
    .mul_strobe (mul_strobe),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_m      (mul_m),
    .mul_p      (mul_p),
    .mul_ready  (mul_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NLEN-1:0] mulmod(input logic [NLEN-1:0] x, y, m);
    logic [2*NLEN-1:0] t;
    logic [2*NLEN-1:0] r;
    if (m == '0) return '0;
    t = {{NLEN{1'b0}}, x} * {{NLEN{1'b0}}, y};
    r = t % {{NLEN{1'b0}}, m};
    return r[NLEN-1:0];
  endfunction

  // Multiplier model: ready stays high until one cycle after the next strobe,
  // and the new product appears L cycles after the strobe cycle.
  int unsigned     mcnt = 0;
  logic [NLEN-1:0] mp_pend = '0;
  always @(posedge clk) begin
    if (mul_strobe) begin
      mcnt    <= L - 1;
      mp_pend <= mulmod(mul_x, mul_y, mul_m);
    end else if (mcnt != 0) begin
      if (mcnt == L - 1) mul_ready <= 1'b0;
      if (mcnt == 1) begin
        mul_ready <= 1'b1;
        mul_p     <= mp_pend;
      end
      mcnt <= mcnt - 1;
    end
  end

  typedef struct {
    logic [NLEN-1:0] res;
    logic            err;
    int unsigned     nstr;
    int unsigned     lat;
    int unsigned     issue;
    int unsigned     str0;
  } exp_t;

  exp_t        sbq[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned total_str = 0;
  int unsigned bad_busy = 0;
  bit          done = 1'b0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int unsigned lat_of(input int unsigned pop);
    return 3 + (1 + ELEN + pop) * (L + 1) + ELEN;
  endfunction

  task automatic wait_idle();
    int unsigned k = 0;
    while ((sbq.size() != 0 || busy) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d, expected idle", busy, sbq.size());
    end
  endtask

  task automatic issue(input logic [NLEN-1:0] b, input logic [ELEN-1:0] e,
                       input logic [NLEN-1:0] m, input bit push,
                       input logic [NLEN-1:0] xres, input logic xerr,
                       input int unsigned xstr, input int unsigned xlat);
    exp_t it;
    wait_idle();
    @(negedge clk);
    #1;
    base = b; exponent = e; modulus = m; strobe = 1'b1;
    if (push) begin
      it.res = xres; it.err = xerr; it.nstr = xstr; it.lat = xlat;
      it.issue = cyc; it.str0 = total_str;
      sbq.push_back(it);
    end
    @(negedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mul_strobe"}, mul_strobe, 0);
    chk({tag, "_mul_x"}, mul_x, 0);
    chk({tag, "_mul_y"}, mul_y, 0);
    chk({tag, "_mul_m"}, mul_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; strobe = 1'b0; base = '0; exponent = '0; modulus = '0;
    fork
      begin : driver
        int unsigned s0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        #1 rst_n = 1'b1;

        issue(32'd4,  32'd13, 32'd497,  1, 32'd445, 1'b0, 36, lat_of(3));
        issue(32'd20, 32'd3,  32'd7,    1, 32'd6,   1'b0, 35, lat_of(2));
        issue(32'd2,  32'd10, 32'd1000, 1, 32'd24,  1'b0, 35, lat_of(2));
        issue(32'd3,  32'd0,  32'd7,    1, 32'd1,   1'b0, 33, lat_of(0));
        issue(32'd5,  32'd0,  32'd1,    1, 32'd0,   1'b0, 33, lat_of(0));
        issue(32'd9,  32'd5,  32'd1,    1, 32'd0,   1'b0, 35, lat_of(2));
        issue(32'd5,  32'd3,  32'd0,    1, 32'd0,   1'b1, 0,  3);
        issue(32'd4,  32'd13, 32'd497,  1, 32'd445, 1'b0, 36, lat_of(3));

        // stray strobe mid-run must be ignored
        issue(32'd4,  32'd13, 32'd497,  1, 32'd445, 1'b0, 36, lat_of(3));
        repeat (20) @(negedge clk);
        #1;
        base = 32'd7; exponent = 32'd5; modulus = 32'd11; strobe = 1'b1;
        @(negedge clk);
        #1 strobe = 1'b0;

        // abort in the first SQR_W cycle; the in-flight product lands after release
        issue(32'd4, 32'd13, 32'd497, 0, '0, 1'b0, 0, 0);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        @(negedge clk);
        #1 rst_n = 1'b1;
        s0 = total_str;
        repeat (12) @(negedge clk);
        chk("abort_no_strobe", total_str - s0, 0);

        issue(32'd2, 32'd10, 32'd1000, 1, 32'd24, 1'b0, 35, lat_of(2));
        wait_idle();
        repeat (3) @(negedge clk);
        chk("busy_gaps", bad_busy, 0);
        done = 1'b1;
      end
      begin : monitor
        exp_t it;
        bit   prev_ready = 1'b0;
        while (!done) begin
          @(negedge clk);
          if (mul_strobe) total_str++;
          if (prev_ready) chk("ready_one_cycle", ready, 0);
          prev_ready = ready;
          if (sbq.size() != 0 && !ready && cyc > sbq[0].issue && busy !== 1'b1)
            bad_busy++;
          if (ready) begin
            if (sbq.size() == 0) begin
              chk("spurious_ready", ready, 0);
            end else begin
              it = sbq.pop_front();
              chk("result", result, it.res);
              chk("err", err, it.err);
              chk("mul_strobe_count", total_str - it.str0, it.nstr);
              chk("latency", cyc - it.issue + 1, it.lat);
              chk("busy_at_ready", busy, 0);
            end
          end
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/modu_exp_ctrl.md
Name: modu_exp_ctrl

Overview:
- Modular exponentiation sequencer: computes result = base^exponent mod modulus.
- Uses left-to-right binary square-and-multiply.
- Sits directly upstream of the modular multiplier (modu_mul_128). It drives the multiplier's strobe/x/y/m and consumes its p/ready, issuing one multiplication at a time.
- Exposes the same strobe/ready/busy handshake to the RSA top-level and Wishbone register block.

Parameters:
- NLEN, 32, width of base, modulus, result and multiplier operands.
- ELEN, 32, exponent width in bits; all ELEN bits are scanned MSB first.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- strobe  in  1  one-cycle start pulse; operands sampled on this edge when idle.
- base  in  NLEN  message/base.
- exponent  in  ELEN  exponent (e or d).
- modulus  in  NLEN  modulus n.
- result  out  NLEN  final value; held until next accepted strobe.
- ready  out  1  one-cycle pulse when result/err are valid.
- busy  out  1  high from the cycle after an accepted strobe until the cycle ready pulses.
- err  out  1  set with ready when modulus==0; cleared on next accepted strobe.
- mul_strobe  out  1  one-cycle start pulse to the multiplier.
- mul_x  out  NLEN  multiplier operand x.
- mul_y  out  NLEN  multiplier operand y.
- mul_m  out  NLEN  multiplier modulus; equals the latched modulus.
- mul_p  in  NLEN  multiplier product.
- mul_ready  in  1  multiplier done.

Behaviour:
- Reset (async, rst_n low): state=IDLE; result=0, ready=0, busy=0, err=0, mul_strobe=0, mul_x=mul_y=mul_m=0. All internal registers are cleared.
- Reset mid-operation aborts immediately. No further mul_strobe is issued after release, even if the multiplier later raises mul_ready.
- Latched operands are B, E, M, R and bit index i.
- State IDLE:
  - strobe=1 latches base, exponent and modulus.
  - If modulus==0: go to DONE with err=1, result=0.
  - Otherwise: R = (modulus==1) ? 0 : 1, i = ELEN-1, go to REDUCE.
  - strobe while not IDLE is ignored.
- State REDUCE: mul_x=B, mul_y=1, pulse mul_strobe for one cycle, go to REDUCE_W. Purpose: reduce the base so that B < M.
- State REDUCE_W: wait for mul_ready, then B = mul_p, go to SQR.
- State SQR: mul_x=R, mul_y=R, pulse mul_strobe, go to SQR_W.
- State SQR_W: on mul_ready, R = mul_p. If E[i]==1 go to MUL, else go to NEXT.
- State MUL: mul_x=R, mul_y=B, pulse mul_strobe, go to MUL_W.
- State MUL_W: on mul_ready, R = mul_p, go to NEXT.
- State NEXT: if i==0 go to DONE; else i = i-1, go to SQR.
- State DONE: result = R, ready=1 for exactly one cycle, busy=0, go to IDLE.
- Multiplier contract:
  - mul_x, mul_y and mul_m are stable from the mul_strobe cycle until mul_ready is sampled.
  - mul_ready is ignored in the first cycle of every *_W state, which guards against a stale level-ready from the previous operation.
  - The multiplier must deassert ready within one cycle of accepting strobe.
- Exactly one outstanding multiplication at any time. mul_strobe is never high in two consecutive cycles.
- mul_strobe count per operation = 1 + ELEN + popcount(exponent). It is 0 when modulus==0.
- Total latency (strobe to ready), for multiplier latency L cycles (strobe to ready) = 2 + Σ over multiplications of (L+1) + ELEN (NEXT cycles) + 1.
  - A fixed L gives a deterministic value; the bench checks it exactly.
- exponent==0: only REDUCE and ELEN squarings of R=1 run. Result is 1, or 0 if modulus==1.
- base ≥ modulus: handled by REDUCE.
- base==0: result 0 for exponent≠0.

Test Plan:
- NLEN=ELEN=32, behavioural multiplier with L=4. base=4, exp=13, mod=497 -> result=445, err=0, ready one cycle, exactly 36 mul_strobe pulses, busy high throughout.
- base=20, exp=3, mod=7 -> result=6 (base > modulus). Then base=2, exp=10, mod=1000 -> result=24. Back-to-back runs with no reset between them; second ready is not triggered early by a stale mul_ready.
- base=3, exp=0, mod=7 -> result=1. Then base=5, exp=0, mod=1 -> result=0. Then base=9, exp=5, mod=1 -> result=0.
- mod=0 (base=5, exp=3) -> ready within 3 cycles, err=1, result=0, zero mul_strobe pulses. The next valid run clears err.
- Strobe pulsed again mid-run with different operands -> ignored; the first operation's result is 445 as above.
- rst_n asserted while in SQR_W -> all outputs 0 immediately. A late mul_ready after release causes no mul_strobe or ready. A new run then yields correct results.
